// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared encodings for the fetch sequencer
package fetch_pkg;
   localparam int ADDR_W_DEF = 16;

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_FLUSH = 2'd2
   } fetch_state_e;

   typedef enum logic [2:0] {
      SRC_NONE = 3'd0,
      SRC_RET  = 3'd1,
      SRC_CALL = 3'd2,
      SRC_JUMP = 3'd3,
      SRC_BR   = 3'd4
   } redir_src_e;
endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - circular return-address stack; a push when full drops the oldest entry
module return_stack #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] ptr;
   logic [PW:0]   count;

   assign top   = mem[ptr];
   assign empty = (count == '0);
   assign full  = (count == FULL_CNT);

   // ptr always names the newest entry, so wrapping it overwrites the oldest.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         ptr           <= ptr + 1'b1;
         mem[ptr + 1'b1] <= din;
         if (!full) count <= count + 1'b1;
      end else if (pop && !empty) begin
         ptr   <= ptr - 1'b1;
         count <= count - 1'b1;
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction-memory sequencer with redirect priority and RAS
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int                ADDR_W    = ADDR_W_DEF,
   parameter int                RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              br_taken_i,
   input  logic [ADDR_W-1:0] br_target_i,
   input  logic              jump_i,
   input  logic              call_i,
   input  logic [ADDR_W-1:0] jmp_target_i,
   input  logic              ret_i,
   input  logic [ADDR_W-1:0] ret_target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              imem_stall_o,
   output logic              if_valid_o,
   output logic              kill_o,
   output logic [ADDR_W-1:0] link_pc_o,
   output logic              ras_empty_o,
   output logic              ras_full_o
);
   fetch_state_e      state_q, state_d;
   redir_src_e        src;
   logic [ADDR_W-1:0] pc_q, pc_d, pc_inc, target, ras_top, link_q;
   logic              ras_push, ras_pop;

   assign pc_inc       = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
   assign pc_o         = pc_q;
   assign link_pc_o    = link_q;
   assign imem_stall_o = stall_i;
   assign if_valid_o   = (state_q == ST_RUN);
   assign kill_o       = (state_q == ST_FLUSH);

   return_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (ras_push),
      .pop   (ras_pop),
      .din   (pc_inc),
      .top   (ras_top),
      .empty (ras_empty_o),
      .full  (ras_full_o)
   );

   // Redirects only count in an unstalled RUN cycle; FLUSH requests come from the killed slot.
   always_comb begin
      src      = SRC_NONE;
      target   = pc_inc;
      ras_push = 1'b0;
      ras_pop  = 1'b0;
      if (state_q == ST_RUN && !stall_i) begin
         if (ret_i) begin
            src     = SRC_RET;
            target  = ras_empty_o ? ret_target_i : ras_top;
            ras_pop = !ras_empty_o;
         end else if (call_i) begin
            src      = SRC_CALL;
            target   = jmp_target_i;
            ras_push = 1'b1;
         end else if (jump_i) begin
            src    = SRC_JUMP;
            target = jmp_target_i;
         end else if (br_taken_i) begin
            src    = SRC_BR;
            target = br_target_i;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (!stall_i) begin
         case (state_q)
            ST_BOOT: begin
               pc_d    = pc_inc;
               state_d = ST_RUN;
            end
            ST_RUN: begin
               pc_d    = target;
               state_d = (src == SRC_NONE) ? ST_RUN : ST_FLUSH;
            end
            ST_FLUSH: begin
               pc_d    = pc_inc;
               state_d = ST_RUN;
            end
            default: begin
               pc_d    = RESET_PC;
               state_d = ST_BOOT;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_BOOT;
         pc_q    <= RESET_PC;
         link_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         if (ras_push) link_q <= pc_inc;
      end
   end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i, br_taken_i, jump_i, call_i, ret_i;
   logic [15:0] br_target_i, jmp_target_i, ret_target_i;
   logic [15:0] pc_o, link_pc_o;
   logic        imem_stall_o, if_valid_o, kill_o, ras_empty_o, ras_full_o;

   typedef struct packed {
      logic [15:0] pc;
      logic        kill;
      logic        valid;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   fetch_sequencer #(.ADDR_W(16), .RAS_DEPTH(4), .RESET_PC(16'h0000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall_i      (stall_i),
      .br_taken_i   (br_taken_i),
      .br_target_i  (br_target_i),
      .jump_i       (jump_i),
      .call_i       (call_i),
      .jmp_target_i (jmp_target_i),
      .ret_i        (ret_i),
      .ret_target_i (ret_target_i),
      .pc_o         (pc_o),
      .imem_stall_o (imem_stall_o),
      .if_valid_o   (if_valid_o),
      .kill_o       (kill_o),
      .link_pc_o    (link_pc_o),
      .ras_empty_o  (ras_empty_o),
      .ras_full_o   (ras_full_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic idle();
      stall_i = 0; br_taken_i = 0; jump_i = 0; call_i = 0; ret_i = 0;
      br_target_i = 0; jmp_target_i = 0; ret_target_i = 0;
   endtask

   // One clock: queue the expected post-edge view, then pop and compare after the edge.
   task automatic go(input logic [15:0] epc, input logic ek, input logic ev);
      exp_t e;
      exp_q.push_back('{pc: epc, kill: ek, valid: ev});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk("pc", {16'h0, pc_o}, {16'h0, e.pc});
      chk("kill", {31'h0, kill_o}, {31'h0, e.kill});
      chk("valid", {31'h0, if_valid_o}, {31'h0, e.valid});
      idle();
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", {16'h0, pc_o}, 32'h0);
      chk("rst_valid", {31'h0, if_valid_o}, 32'h0);
      chk("rst_kill", {31'h0, kill_o}, 32'h0);
      chk("rst_link", {16'h0, link_pc_o}, 32'h0);
      chk("rst_empty", {31'h0, ras_empty_o}, 32'h1);
      chk("rst_full", {31'h0, ras_full_o}, 32'h0);
      rst_n = 1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      do_reset();
      // Boot then sequential fetch
      go(16'h1, 0, 1); go(16'h2, 0, 1); go(16'h3, 0, 1);

      // Branch from pc 1
      do_reset();
      go(16'h1, 0, 1);
      br_taken_i = 1; br_target_i = 16'h2; go(16'h2, 1, 0);
      go(16'h3, 0, 1);

      // Stalled jump is held off, then accepted
      stall_i = 1; jump_i = 1; jmp_target_i = 16'd12;
      #1 chk("imem_stall", {31'h0, imem_stall_o}, 32'h1);
      go(16'h3, 0, 1);
      stall_i = 1; jump_i = 1; jmp_target_i = 16'd12; go(16'h3, 0, 1);
      jump_i = 1; jmp_target_i = 16'd12; go(16'd12, 1, 0);
      go(16'd13, 0, 1);

      // Redirect during FLUSH is ignored; stall holds FLUSH
      jump_i = 1; jmp_target_i = 16'd20; go(16'd20, 1, 0);
      br_taken_i = 1; br_target_i = 16'd50; go(16'd21, 0, 1);
      jump_i = 1; jmp_target_i = 16'd30; go(16'd30, 1, 0);
      stall_i = 1; go(16'd30, 1, 0);
      go(16'd31, 0, 1);

      // Call at pc 0, return through the RAS
      jump_i = 1; jmp_target_i = 16'hFFFF; go(16'hFFFF, 1, 0);
      go(16'h0000, 0, 1);
      call_i = 1; jmp_target_i = 16'd10; go(16'd10, 1, 0);
      chk("link_call0", {16'h0, link_pc_o}, 32'h1);
      chk("empty_after_call", {31'h0, ras_empty_o}, 32'h0);
      go(16'd11, 0, 1);
      ret_i = 1; ret_target_i = 16'h0099; go(16'h1, 1, 0);
      chk("empty_after_ret", {31'h0, ras_empty_o}, 32'h1);
      go(16'h2, 0, 1);

      // Five nested calls overflow the 4-deep RAS
      for (int i = 1; i <= 5; i++) begin
         call_i = 1; jmp_target_i = 16'(i * 16'h100);
         go(16'(i * 16'h100), 1, 0);
         go(16'(i * 16'h100 + 1), 0, 1);
      end
      chk("link_5th", {16'h0, link_pc_o}, 32'h402);
      chk("full_after_5", {31'h0, ras_full_o}, 32'h1);
      for (int i = 4; i >= 1; i--) begin
         ret_i = 1; ret_target_i = 16'h0040;
         go(16'(i * 16'h100 + 2), 1, 0);
         go(16'(i * 16'h100 + 3), 0, 1);
      end
      chk("empty_after_4_rets", {31'h0, ras_empty_o}, 32'h1);
      ret_i = 1; ret_target_i = 16'h0040; go(16'h0040, 1, 0);
      go(16'h0041, 0, 1);

      // PC wrap in RUN
      jump_i = 1; jmp_target_i = 16'hFFFE; go(16'hFFFE, 1, 0);
      go(16'hFFFF, 0, 1);
      go(16'h0000, 0, 1);

      // Priority: ret over branch, ret over call (no push), jump over branch
      ret_i = 1; ret_target_i = 16'h0077; br_taken_i = 1; br_target_i = 16'h0088;
      go(16'h0077, 1, 0);
      go(16'h0078, 0, 1);
      ret_i = 1; ret_target_i = 16'h0066; call_i = 1; jmp_target_i = 16'h0055;
      go(16'h0066, 1, 0);
      chk("ret_call_no_push", {31'h0, ras_empty_o}, 32'h1);
      chk("ret_call_link", {16'h0, link_pc_o}, 32'h402);
      go(16'h0067, 0, 1);
      jump_i = 1; jmp_target_i = 16'h0030; br_taken_i = 1; br_target_i = 16'h0031;
      go(16'h0030, 1, 0);

      // Asynchronous reset mid-operation
      call_i = 1; jmp_target_i = 16'h0200;
      @(negedge clk);
      rst_n = 0;
      #1;
      chk("async_pc", {16'h0, pc_o}, 32'h0);
      chk("async_kill", {31'h0, kill_o}, 32'h0);
      chk("async_valid", {31'h0, if_valid_o}, 32'h0);
      chk("async_link", {16'h0, link_pc_o}, 32'h0);
      idle();
      @(posedge clk); #1;
      rst_n = 1;
      go(16'h1, 0, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
